// File: rtl/axum_host_arb.sv
// axum_host_arb: round-robin arbiter sharing one req/gnt/rvalid host port
// among NrHosts upstream hosts. Accepted transactions record the issuing host
// in a small ID FIFO so in-order responses are routed back to their origin.
// Requests, grants and responses pass through combinationally.
module axum_host_arb #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrHosts-1:0]             host_req_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*4-1:0]           host_be_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [DataWidth-1:0]           host_rdata_o,
  output logic [NrHosts-1:0]             host_err_o,
  output logic                           out_req_o,
  input  logic                           out_gnt_i,
  output logic [AddressWidth-1:0]        out_addr_o,
  output logic                           out_we_o,
  output logic [3:0]                     out_be_o,
  output logic [DataWidth-1:0]           out_wdata_o,
  input  logic                           out_rvalid_i,
  input  logic [DataWidth-1:0]           out_rdata_i,
  input  logic                           out_err_i,
  output logic                           spurious_o
);

  localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdW-1:0]  id_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // Unpacked views of the packed per-host payload buses.
  logic [AddressWidth-1:0] addr_arr  [NrHosts];
  logic [3:0]              be_arr    [NrHosts];
  logic [DataWidth-1:0]    wdata_arr [NrHosts];

  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_unpack
    assign addr_arr[gi]  = host_addr_i[gi*AddressWidth +: AddressWidth];
    assign be_arr[gi]    = host_be_i[gi*4 +: 4];
    assign wdata_arr[gi] = host_wdata_i[gi*DataWidth +: DataWidth];
  end

  // State
  id_t  rr_ptr_q, rr_ptr_d;
  logic lock_q, lock_d;
  id_t  locked_id_q, locked_id_d;
  cnt_t count_q, count_d;
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  logic spurious_q, spurious_d;
  id_t  id_fifo_q [MaxOutstanding];

  id_t        scan_sel;
  id_t        sel;
  id_t        src;
  id_t        head;
  logic       accept;
  logic       pop;
  logic [IdW:0] cand;
  logic       found;

  // Round-robin scan starting at rr_ptr, wrapping modulo NrHosts.
  always_comb begin
    scan_sel = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NrHosts; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(NrHosts)) cand = cand - (IdW+1)'(NrHosts);
      if (!found && host_req_i[cand[IdW-1:0]]) begin
        found    = 1'b1;
        scan_sel = cand[IdW-1:0];
      end
    end
  end

  // A stalled request keeps its host so the downstream sees a stable request.
  assign sel       = lock_q ? locked_id_q : scan_sel;
  assign out_req_o = (lock_q | (|host_req_i)) & (count_q < cnt_t'(MaxOutstanding));
  assign accept    = out_req_o & out_gnt_i;
  assign pop       = out_rvalid_i & (count_q != '0);
  assign head      = id_fifo_q[rptr_q];

  // Idle payload comes from host 0; downstream ignores it without a request.
  assign src          = out_req_o ? sel : '0;
  assign out_addr_o   = addr_arr[src];
  assign out_we_o     = host_we_i[src];
  assign out_be_o     = be_arr[src];
  assign out_wdata_o  = wdata_arr[src];
  assign host_rdata_o = out_rdata_i;
  assign spurious_o   = spurious_q;

  // Same-cycle grant to the selected host and response routing to the FIFO head.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (accept) host_gnt_o[sel] = 1'b1;
    if (pop) begin
      host_rvalid_o[head] = 1'b1;
      host_err_o[head]    = out_err_i;
    end
  end

  // Next-state: round-robin pointer, lock, FIFO pointers/occupancy, spurious flag.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    spurious_d  = spurious_q | (out_rvalid_i & (count_q == '0));
    if (accept) begin
      rr_ptr_d = (sel == id_t'(NrHosts-1)) ? '0 : sel + id_t'(1);
      lock_d   = 1'b0;
      wptr_d   = (wptr_q == ptr_t'(MaxOutstanding-1)) ? '0 : wptr_q + ptr_t'(1);
    end else if (out_req_o) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end
    if (pop) begin
      rptr_d = (rptr_q == ptr_t'(MaxOutstanding-1)) ? '0 : rptr_q + ptr_t'(1);
    end
    if (accept && !pop)      count_d = count_q + cnt_t'(1);
    else if (pop && !accept) count_d = count_q - cnt_t'(1);
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      spurious_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      spurious_q  <= spurious_d;
    end
  end

  // ID FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) id_fifo_q[wptr_q] <= sel;
  end

endmodule

// File: doc/axum_host_arb.md
Name: axum_host_arb

Overview:
- Round-robin arbiter that lets NrHosts bus hosts share one host port of the system bus.
- Intended users are the Ibex data port plus upcoming DMA and debug-loader masters.
- Uses the same req/gnt/rvalid protocol on both sides.
- Tracks outstanding transactions in an ID FIFO so each in-order response returns to the host that issued it.

Parameters:
- NrHosts, 2, number of upstream hosts (≥2).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (≥1).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- host_req_i  input  NrHosts  per-host request
- host_gnt_o  output  NrHosts  per-host grant
- host_addr_i  input  NrHosts*AddressWidth  per-host address, packed, host 0 in LSBs
- host_we_i  input  NrHosts  per-host write enable
- host_be_i  input  NrHosts*4  per-host byte enables
- host_wdata_i  input  NrHosts*DataWidth  per-host write data
- host_rvalid_o  output  NrHosts  per-host response valid
- host_rdata_o  output  DataWidth  response data, shared by all hosts
- host_err_o  output  NrHosts  per-host response error
- out_req_o  output  1  downstream request
- out_gnt_i  input  1  downstream grant
- out_addr_o  output  AddressWidth  downstream address
- out_we_o  output  1  downstream write enable
- out_be_o  output  4  downstream byte enables
- out_wdata_o  output  DataWidth  downstream write data
- out_rvalid_i  input  1  downstream response valid
- out_rdata_i  input  DataWidth  downstream response data
- out_err_i  input  1  downstream response error
- spurious_o  output  1  sticky flag: response received with no outstanding transaction

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_i is asynchronous, active-high.
- Reset state:
  - rr_ptr=0, count=0, lock=0, spurious_o=0.
  - Combinational outputs follow from this state: host_gnt_o=0, host_rvalid_o=0, host_err_o=0.
  - out_req_o=0 while no host_req_i is asserted.
- Selection:
  - If lock=0, sel = first i with host_req_i[i]=1, scanning rr_ptr, rr_ptr+1, … mod NrHosts.
  - If lock=1, sel = locked_id.
- Issue:
  - out_req_o = (lock | any host_req_i) & (count < MaxOutstanding).
  - out_addr/we/be/wdata are muxed from sel.
  - When out_req_o=0 these outputs are driven from host 0; downstream ignores them.
- Lock:
  - When out_req_o=1 and out_gnt_i=0: lock<=1, locked_id<=sel.
  - The selection is then held until granted, so the downstream sees stable req/addr.
  - Hosts hold req and payload until their gnt; this is the protocol rule.
- Grant:
  - host_gnt_o[sel] = out_req_o & out_gnt_i, combinational, same cycle. All other bits are 0.
  - On acceptance: push sel to the ID FIFO, rr_ptr <= (sel+1) mod NrHosts, lock <= 0.
- FIFO full:
  - When count==MaxOutstanding, out_req_o=0 and no grant is given.
  - This holds even if out_rvalid_i arrives in the same cycle; that pop frees the slot for the next cycle only.
- Response:
  - On out_rvalid_i with count>0: host_rvalid_o[head]=1 and host_err_o[head]=out_err_i; pop the FIFO.
  - host_rdata_o = out_rdata_i always, unregistered.
  - Zero added latency in both directions.
- Simultaneous push and pop: count unchanged; FIFO head advances and the new tail is written.
- Spurious response:
  - out_rvalid_i with count==0: no host_rvalid_o bit is asserted.
  - spurious_o <= 1 and stays set until reset.
- Downstream rule: responses arrive at least 1 cycle after the grant and strictly in order. The arbiter does not reorder.
- ID FIFO:
  - Circular buffer of MaxOutstanding entries, each $clog2(NrHosts) bits wide.
  - Read and write pointers wrap modulo MaxOutstanding.
- Reset mid-transaction:
  - Outstanding IDs are discarded.
  - Later late responses raise spurious_o rather than being delivered.

Test Plan:
- Single host: host0 read of addr 0x100000 granted at cycle 1, rvalid at cycle 2 -> host_rvalid_o=01, host_rdata_o=out_rdata_i, count returns to 0.
- Fairness: host0 and host1 request continuously, out_gnt_i=1, rvalid one cycle later -> grants alternate 01,10,01,10; rr_ptr toggles every cycle.
- Lock: host0 requests with out_gnt_i=0 for 3 cycles while host1 also requests -> out_addr_o holds host0 address; first grant goes to host0, next grant to host1.
- Full: MaxOutstanding=2 with rvalid withheld -> exactly 2 grants, then out_req_o=0. One rvalid pulse re-enables out_req_o the following cycle.
- Routing and error: grant host1 then host0, then two rvalids with out_err_i=1,0 -> host_err_o=10 on the first response, host_rvalid_o=01 with err=0 on the second.
- Spurious and reset: pulse out_rvalid_i with count=0 -> spurious_o=1 from the next cycle, no host_rvalid_o. Assert rst_i with 1 outstanding -> count=0, spurious_o=0, rr_ptr=0 immediately.
